// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: commits an encoded exception/interrupt from the MEM stage.
// Drains an outstanding data-bus access and writes CP0 in one COMMIT cycle
// together with a pipeline flush. It then holds the redirect PC until IF
// accepts it. The encode_* values below must match the MEM-stage encoder.
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      pc_i,
  input  logic             in_delayslot_i,
  input  logic [31:0]      badvaddr_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             mem_busy_i,
  input  logic             if_ready_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             new_pc_valid_o,
  output logic             cp0_exc_we_o,
  output logic [4:0]       cp0_exc_code_o,
  output logic             cp0_bd_o,
  output logic [31:0]      cp0_epc_o,
  output logic             cp0_badv_we_o,
  output logic [31:0]      cp0_badv_o,
  output logic             cp0_exl_clr_o,
  output logic [CNT_W-1:0] exc_cnt_o
);

  localparam logic [31:0] ENC_INT0    = 32'h0000_0001;
  localparam logic [31:0] ENC_INT7    = 32'h0000_0008;
  localparam logic [31:0] ENC_ADEL_IF = 32'h0000_0010;
  localparam logic [31:0] ENC_ADEL_LD = 32'h0000_0011;
  localparam logic [31:0] ENC_ADES    = 32'h0000_0012;
  localparam logic [31:0] ENC_SYS     = 32'h0000_0013;
  localparam logic [31:0] ENC_BP      = 32'h0000_0014;
  localparam logic [31:0] ENC_RI      = 32'h0000_0015;
  localparam logic [31:0] ENC_OV      = 32'h0000_0016;
  localparam logic [31:0] ENC_TR      = 32'h0000_0017;
  localparam logic [31:0] ENC_ERET    = 32'h0000_0018;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

  // Encoded code to Cause.ExcCode; unknown nonzero codes report reserved instruction.
  function automatic logic [4:0] exc_code_map(input logic [31:0] code);
    logic [4:0] res;
    res = 5'd10;
    if (code == 32'd0) begin
      res = 5'd0;
    end else if (code >= ENC_INT0 && code <= ENC_INT7) begin
      res = 5'd0;
    end else begin
      case (code)
        ENC_ADEL_IF, ENC_ADEL_LD: res = 5'd4;
        ENC_ADES:                 res = 5'd5;
        ENC_SYS:                  res = 5'd8;
        ENC_BP:                   res = 5'd9;
        ENC_RI:                   res = 5'd10;
        ENC_OV:                   res = 5'd12;
        ENC_TR:                   res = 5'd13;
        default:                  res = 5'd10;
      endcase
    end
    return res;
  endfunction

  function automatic logic has_badv(input logic [31:0] code);
    return (code == ENC_ADEL_IF) || (code == ENC_ADEL_LD) || (code == ENC_ADES);
  endfunction

  state_t            state;
  logic [31:0]       code_q;
  logic [31:0]       pc_q;
  logic              ds_q;
  logic [31:0]       badv_q;
  logic [31:0]       new_pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              flush_q;
  logic              exc_we_q;
  logic              exl_clr_q;
  logic              badv_we_q;
  logic              valid_q;
  logic [31:0]       commit_code;
  logic              enter_commit;

  // The code about to commit: live input when leaving IDLE, latched copy from DRAIN.
  assign commit_code  = (state == IDLE) ? excepttype_i : code_q;
  assign enter_commit = !mem_busy_i &&
                        ((state == IDLE && excepttype_i != 32'd0) || state == DRAIN);

  // Sequencer with registered one-cycle COMMIT strobes and held redirect request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      code_q    <= 32'd0;
      pc_q      <= 32'd0;
      ds_q      <= 1'b0;
      badv_q    <= 32'd0;
      new_pc_q  <= EXC_VECTOR;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      exc_we_q  <= 1'b0;
      exl_clr_q <= 1'b0;
      badv_we_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      flush_q   <= enter_commit;
      exc_we_q  <= enter_commit && (commit_code != ENC_ERET);
      exl_clr_q <= enter_commit && (commit_code == ENC_ERET);
      badv_we_q <= enter_commit && has_badv(commit_code);
      case (state)
        IDLE: begin
          if (excepttype_i != 32'd0) begin
            code_q <= excepttype_i;
            pc_q   <= pc_i;
            ds_q   <= in_delayslot_i;
            badv_q <= badvaddr_i;
            state  <= mem_busy_i ? DRAIN : COMMIT;
          end
        end
        DRAIN: begin
          if (!mem_busy_i) state <= COMMIT;
        end
        COMMIT: begin
          new_pc_q <= (code_q == ENC_ERET) ? cp0_epc_i : EXC_VECTOR;
          cnt_q    <= cnt_q + CNT_ONE;
          valid_q  <= 1'b1;
          state    <= REDIRECT;
        end
        REDIRECT: begin
          if (if_ready_i) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_o        = (state != IDLE) || (excepttype_i != 32'd0);
  assign flush_o        = flush_q;
  assign new_pc_o       = new_pc_q;
  assign new_pc_valid_o = valid_q;
  assign cp0_exc_we_o   = exc_we_q;
  assign cp0_exl_clr_o  = exl_clr_q;
  assign cp0_badv_we_o  = badv_we_q;
  assign cp0_exc_code_o = exc_code_map(code_q);
  assign cp0_bd_o       = ds_q;
  assign cp0_epc_o      = ds_q ? (pc_q - 32'd4) : pc_q;
  assign cp0_badv_o     = (code_q == ENC_ADEL_IF) ? pc_q : badv_q;
  assign exc_cnt_o      = cnt_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: cycle model plus directed sequences with literal expectations.
module tb_exc_commit_ctrl;

  localparam logic [31:0] VEC      = 32'hBFC0_0380;
  localparam logic [31:0] E_INT0   = 32'h01;
  localparam logic [31:0] E_INT3   = 32'h04;
  localparam logic [31:0] E_INT7   = 32'h08;
  localparam logic [31:0] E_ADELIF = 32'h10;
  localparam logic [31:0] E_ADELLD = 32'h11;
  localparam logic [31:0] E_ADES   = 32'h12;
  localparam logic [31:0] E_SYS    = 32'h13;
  localparam logic [31:0] E_BP     = 32'h14;
  localparam logic [31:0] E_RI     = 32'h15;
  localparam logic [31:0] E_OV     = 32'h16;
  localparam logic [31:0] E_TR     = 32'h17;
  localparam logic [31:0] E_ERET   = 32'h18;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] excepttype_i = 32'd0;
  logic [31:0] pc_i = 32'd0;
  logic        in_delayslot_i = 1'b0;
  logic [31:0] badvaddr_i = 32'd0;
  logic [31:0] cp0_epc_i = 32'd0;
  logic        mem_busy_i = 1'b0;
  logic        if_ready_i = 1'b1;
  logic        stall_o, flush_o, new_pc_valid_o, cp0_exc_we_o, cp0_bd_o;
  logic        cp0_badv_we_o, cp0_exl_clr_o;
  logic [31:0] new_pc_o, cp0_epc_o, cp0_badv_o;
  logic [4:0]  cp0_exc_code_o;
  logic [3:0]  exc_cnt_o;

  int checks = 0;
  int errors = 0;

  exc_commit_ctrl #(.EXC_VECTOR(VEC), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .excepttype_i(excepttype_i), .pc_i(pc_i),
    .in_delayslot_i(in_delayslot_i), .badvaddr_i(badvaddr_i), .cp0_epc_i(cp0_epc_i),
    .mem_busy_i(mem_busy_i), .if_ready_i(if_ready_i), .stall_o(stall_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .new_pc_valid_o(new_pc_valid_o),
    .cp0_exc_we_o(cp0_exc_we_o), .cp0_exc_code_o(cp0_exc_code_o), .cp0_bd_o(cp0_bd_o),
    .cp0_epc_o(cp0_epc_o), .cp0_badv_we_o(cp0_badv_we_o), .cp0_badv_o(cp0_badv_o),
    .cp0_exl_clr_o(cp0_exl_clr_o), .exc_cnt_o(exc_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] spec_code(input logic [31:0] c);
    if (c >= E_INT0 && c <= E_INT7) return 5'd0;
    if (c == E_ADELIF || c == E_ADELLD) return 5'd4;
    if (c == E_ADES) return 5'd5;
    if (c == E_SYS) return 5'd8;
    if (c == E_BP) return 5'd9;
    if (c == E_OV) return 5'd12;
    if (c == E_TR) return 5'd13;
    return 5'd10;
  endfunction

  // Behavioural model: an accepted exception waits for the bus, commits once, then redirects.
  logic        armed = 1'b0;
  logic        m_wait, m_commit, m_redir, m_ds;
  logic [31:0] m_code, m_pc, m_badv, m_newpc;
  logic [3:0]  m_cnt;

  always @(posedge clk) begin
    armed <= 1'b1;
    if (!resetn) begin
      m_wait <= 1'b0; m_commit <= 1'b0; m_redir <= 1'b0; m_cnt <= 4'd0;
      m_newpc <= VEC; m_code <= 32'd0; m_pc <= 32'd0; m_ds <= 1'b0; m_badv <= 32'd0;
    end else if (m_redir) begin
      if (if_ready_i) m_redir <= 1'b0;
    end else if (m_commit) begin
      m_commit <= 1'b0;
      m_redir  <= 1'b1;
      m_newpc  <= (m_code == E_ERET) ? cp0_epc_i : VEC;
      m_cnt    <= m_cnt + 4'd1;
    end else if (m_wait) begin
      if (!mem_busy_i) begin m_wait <= 1'b0; m_commit <= 1'b1; end
    end else if (excepttype_i != 32'd0) begin
      m_code <= excepttype_i; m_pc <= pc_i; m_ds <= in_delayslot_i; m_badv <= badvaddr_i;
      if (mem_busy_i) m_wait <= 1'b1; else m_commit <= 1'b1;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      logic eret, bv;
      eret = (m_code == E_ERET);
      bv   = m_commit && (m_code == E_ADELIF || m_code == E_ADELLD || m_code == E_ADES);
      cmp("stall", 32'(stall_o), 32'(m_wait || m_commit || m_redir || excepttype_i != 32'd0));
      cmp("flush", 32'(flush_o), 32'(m_commit));
      cmp("exc_we", 32'(cp0_exc_we_o), 32'(m_commit && !eret));
      cmp("exl_clr", 32'(cp0_exl_clr_o), 32'(m_commit && eret));
      cmp("badv_we", 32'(cp0_badv_we_o), 32'(bv));
      cmp("pc_valid", 32'(new_pc_valid_o), 32'(m_redir));
      cmp("new_pc", new_pc_o, m_newpc);
      cmp("cnt", 32'(exc_cnt_o), 32'(m_cnt));
      if (m_commit) begin
        cmp("exc_code", 32'(cp0_exc_code_o), 32'(spec_code(m_code)));
        cmp("epc", cp0_epc_o, m_ds ? m_pc - 32'd4 : m_pc);
        cmp("bd", 32'(cp0_bd_o), 32'(m_ds));
      end
      if (bv) cmp("badv", cp0_badv_o, (m_code == E_ADELIF) ? m_pc : m_badv);
    end
  end

  int n_drain, n_commit, n_valid, n_total;
  logic [31:0] cap_epc, cap_badv, cap_newpc;
  logic [4:0]  cap_code;
  logic        cap_bd, cap_bwe, cap_we, cap_exl;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one code, hold the bus busy and IF not-ready as asked, observe until IDLE.
  task automatic do_exc(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                        input logic [31:0] badv, input int busy_n, input int hold_n,
                        input logic [31:0] intruder);
    int busy_left;
    logic seen, done;
    busy_left = busy_n; seen = 1'b0; done = 1'b0;
    n_drain = 0; n_commit = 0; n_valid = 0; n_total = 0;
    excepttype_i = code; pc_i = pc; in_delayslot_i = ds; badvaddr_i = badv;
    mem_busy_i = (busy_n > 0); if_ready_i = (hold_n == 0);
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (k > 0 && stall_o && !flush_o && !new_pc_valid_o) n_drain++;
      if (flush_o) begin
        n_commit++;
        cap_code = cp0_exc_code_o; cap_epc = cp0_epc_o; cap_bd = cp0_bd_o;
        cap_bwe = cp0_badv_we_o; cap_badv = cp0_badv_o; cap_we = cp0_exc_we_o;
        cap_exl = cp0_exl_clr_o;
      end
      if (new_pc_valid_o) begin
        if (!seen) cap_newpc = new_pc_o;
        n_valid++; seen = 1'b1;
      end else if (seen) begin
        done = 1'b1; n_total = k;
      end
      if (!done) begin
        tick();
        excepttype_i = (seen && n_valid == 1) ? intruder : 32'd0;
        busy_left--;
        mem_busy_i = (busy_left > 0);
        if (seen && n_valid >= hold_n) if_ready_i = 1'b1;
      end
    end
    if (!done) cmp("timeout", 32'd1, 32'd0);
    excepttype_i = 32'd0; mem_busy_i = 1'b0; if_ready_i = 1'b1;
  endtask

  logic [31:0] tbl_code [8];
  logic [4:0]  tbl_exp  [8];

  initial begin
    tbl_code = '{E_INT0, E_INT7, E_BP, E_RI, E_OV, E_TR, E_ADELIF, 32'h0000_0100};
    tbl_exp  = '{5'd0, 5'd0, 5'd9, 5'd10, 5'd12, 5'd13, 5'd4, 5'd10};

    tick(); tick();
    @(negedge clk);
    cmp("rst_stall", 32'(stall_o), 32'd0);
    cmp("rst_newpc", new_pc_o, VEC);
    cmp("rst_cnt", 32'(exc_cnt_o), 32'd0);
    cmp("rst_code", 32'(cp0_exc_code_o), 32'd0);
    cmp("rst_epc", cp0_epc_o, 32'd0);
    cmp("rst_valid", 32'(new_pc_valid_o), 32'd0);
    tick(); resetn = 1'b1;

    // Sys, best-case path
    do_exc(E_SYS, 32'h8000_0100, 1'b0, 32'd0, 0, 0, 32'd0);
    cmp("sys_code", 32'(cap_code), 32'd8);
    cmp("sys_epc", cap_epc, 32'h8000_0100);
    cmp("sys_bd", 32'(cap_bd), 32'd0);
    cmp("sys_bwe", 32'(cap_bwe), 32'd0);
    cmp("sys_newpc", cap_newpc, 32'hBFC0_0380);
    cmp("sys_total", 32'(n_total), 32'd3);
    cmp("sys_cnt", 32'(exc_cnt_o), 32'd1);

    // AdEL_ld in a delay slot
    do_exc(E_ADELLD, 32'h8000_0204, 1'b1, 32'h0000_1003, 0, 0, 32'd0);
    cmp("adel_code", 32'(cap_code), 32'd4);
    cmp("adel_epc", cap_epc, 32'h8000_0200);
    cmp("adel_bd", 32'(cap_bd), 32'd1);
    cmp("adel_badv", cap_badv, 32'h0000_1003);

    // AdES behind a 4-cycle busy bus
    do_exc(E_ADES, 32'h8000_0300, 1'b0, 32'h0000_2002, 4, 0, 32'd0);
    cmp("ades_drain", 32'(n_drain), 32'd4);
    cmp("ades_commit", 32'(n_commit), 32'd1);
    cmp("ades_code", 32'(cap_code), 32'd5);

    // eret
    cp0_epc_i = 32'h8000_0480;
    do_exc(E_ERET, 32'h8000_0400, 1'b0, 32'd0, 0, 0, 32'd0);
    cmp("eret_we", 32'(cap_we), 32'd0);
    cmp("eret_exl", 32'(cap_exl), 32'd1);
    cmp("eret_newpc", cap_newpc, 32'h8000_0480);

    // Redirect held 5 cycles with an Int3 arriving during REDIRECT
    do_exc(E_SYS, 32'h8000_0500, 1'b0, 32'd0, 0, 5, E_INT3);
    cmp("hold_valid", 32'(n_valid), 32'd6);
    cmp("hold_commit", 32'(n_commit), 32'd1);
    cmp("hold_cnt", 32'(exc_cnt_o), 32'd5);

    // Remaining code mapping
    for (int i = 0; i < 8; i++) begin
      do_exc(tbl_code[i], 32'h8000_0600, 1'b0, 32'h0000_DEAD, 0, 0, 32'd0);
      cmp("map_code", 32'(cap_code), 32'(tbl_exp[i]));
      if (tbl_code[i] == E_ADELIF) cmp("adelif_badv", cap_badv, 32'h8000_0600);
    end

    // Reset during DRAIN
    excepttype_i = E_ADES; mem_busy_i = 1'b1;
    tick(); excepttype_i = 32'd0;
    tick();
    @(negedge clk);
    cmp("drain_stall", 32'(stall_o), 32'd1);
    tick(); resetn = 1'b0;
    tick(); resetn = 1'b1; mem_busy_i = 1'b0;
    @(negedge clk);
    cmp("drst_stall", 32'(stall_o), 32'd0);
    cmp("drst_cnt", 32'(exc_cnt_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("drst_flush", 32'(flush_o), 32'd0);
    end

    // Reset during REDIRECT
    tick();
    excepttype_i = E_SYS; if_ready_i = 1'b0;
    tick(); excepttype_i = 32'd0;
    tick();
    @(negedge clk);
    cmp("rrst_valid_pre", 32'(new_pc_valid_o), 32'd1);
    tick(); resetn = 1'b0;
    tick(); resetn = 1'b1; if_ready_i = 1'b1;
    @(negedge clk);
    cmp("rrst_valid", 32'(new_pc_valid_o), 32'd0);
    cmp("rrst_cnt", 32'(exc_cnt_o), 32'd0);
    cmp("rrst_newpc", new_pc_o, VEC);
    tick();

    // Counter wrap: reach all-ones, then commit once more
    for (int i = 0; i < 15; i++) do_exc(E_SYS, 32'h8000_0700, 1'b0, 32'd0, 0, 0, 32'd0);
    cmp("cnt_full", 32'(exc_cnt_o), 32'd15);
    do_exc(E_SYS, 32'h8000_0700, 1'b0, 32'd0, 0, 0, 32'd0);
    cmp("cnt_wrap", 32'(exc_cnt_o), 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
